adder_tree_pipe: RTL
====================

ADDER_TREE_PIPE -- requirements
Module: adder_tree_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 8: bit width of each operand.
REQ-002 SHALL have parameter N, default 4: operand count; legal values are powers of two, 2..64.
REQ-003 SHALL have parameter SIGNED, default 0: 0 treats operands as unsigned, 1 treats them as two's complement.
REQ-004 SHALL define local parameters L = log2(N) and OW = WIDTH + L.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-007 SHALL have port in_data, input, N*WIDTH bits: packed operands; operand k occupies bits [k*WIDTH +: WIDTH].
REQ-008 SHALL have port in_mask, input, N bits: bit k = 1 replaces operand k with zero for this beat.
REQ-009 SHALL have port in_valid, input, 1 bit: an input beat is offered.
REQ-010 SHALL have port in_ready, output, 1 bit: the block accepts the offered beat this cycle.
REQ-011 SHALL have port out_sum, output, OW bits: sum of all unmasked operands for one beat.
REQ-012 SHALL have port out_valid, output, 1 bit: out_sum holds a result.
REQ-013 SHALL have port out_ready, input, 1 bit: the consumer accepts the result this cycle.

Function
REQ-014 SHALL implement a binary adder tree of L levels, with one register stage per level; level j holds N/2^(j+1) partial sums, each WIDTH+j+1 bits wide.
REQ-015 SHALL sign-extend operands and partial sums when SIGNED=1 and zero-extend them when SIGNED=0; no result SHALL overflow OW bits.
REQ-016 SHALL apply in_mask before the first adder level.
REQ-017 SHALL give each stage a valid bit; the final stage registers drive out_sum and out_valid directly.
REQ-018 SHALL use a global advance signal adv = !out_valid || out_ready; all stage registers and valid bits update only when adv = 1.
REQ-019 SHALL drive in_ready = adv while rst_n = 1; an input beat transfers when in_valid && in_ready.
REQ-020 SHALL give a latency of exactly L cycles from an input transfer to out_valid, with no stalls; for L = 1 the single stage is the output stage.
REQ-021 SHALL, when adv = 1, load stage 0's valid bit with in_valid && in_ready; a bubble SHALL propagate as valid = 0 and its data SHALL be don't-care internally.
REQ-022 SHALL hold out_sum and out_valid stable while out_valid && !out_ready (backpressure); no beat SHALL be lost or duplicated.
REQ-023 SHALL sustain one result per cycle when out_ready is held at 1.
REQ-024 SHALL preserve beat order; the block never reorders or drops accepted beats.
REQ-025 SHALL keep the output valid for a beat with all bits of in_mask set, producing out_sum = 0.

Reset
REQ-026 SHALL, while rst_n = 0 at a clock edge, clear every stage valid bit, every partial-sum register and out_sum to 0, and set out_valid = 0.
REQ-027 SHALL drive in_ready = 0 combinationally while rst_n = 0.
REQ-028 SHALL discard all in-flight beats when reset is asserted mid-operation; no result for those beats appears after reset.
REQ-029 SHALL, on the first cycle after reset release, hold in_ready = 1 (pipeline empty).

Verification (WIDTH=8, N=4, L=2, OW=10 unless noted)
REQ-030 SHALL cover full-scale unsigned: SIGNED=0, operands {255,255,255,255}, mask 0, out_ready=1 -> out_sum=1020, out_valid exactly 2 cycles after transfer.
REQ-031 SHALL cover signed extremes: SIGNED=1, operands {-128,-128,-128,-128} -> out_sum=10'h200 (-512); operands {127,-1,0,1} -> out_sum=127.
REQ-032 SHALL cover masking: operands {10,20,30,40}, in_mask=4'b0101 -> out_sum=60; in_mask=4'b1111 -> out_sum=0 with out_valid=1.
REQ-033 SHALL cover backpressure: stream the sums 1,2,3,4,5 back-to-back, with out_ready=0 for 3 cycles mid-stream -> out_sum is held stable, in_ready=0 while full, and all five results emerge in order with none lost or duplicated.
REQ-034 SHALL cover reset mid-stream: assert rst_n=0 for 1 cycle with 2 beats in flight -> out_valid=0 and out_sum=0 next cycle, the dropped beats never appear, and in_ready=1 after release.
REQ-035 SHALL cover a parameter sweep: N=2 (L=1, latency 1) and N=8, WIDTH=4, with 8x operand 15 -> out_sum=120, OW=7.

Source files
------------

// File: rtl/adder_tree_pipe.sv
// adder_tree_pipe: pipelined binary adder tree summing N operands of WIDTH bits.
// One register stage per tree level and a valid bit per stage. A single global
// advance (adv) stalls the whole pipeline while the output holds an unconsumed
// result.
//
// Ports
//   clk       : clock, all state updates on the rising edge
//   rst_n     : synchronous active-low reset
//   in_data   : N packed operands, operand k at [k*WIDTH +: WIDTH]
//   in_mask   : bit k = 1 zeroes operand k for this beat
//   in_valid  : input beat offered
//   in_ready  : input beat accepted this cycle
//   out_sum   : sum of unmasked operands, WIDTH+log2(N) bits
//   out_valid : out_sum holds a result
//   out_ready : consumer accepts the result this cycle
module adder_tree_pipe #(
   parameter int unsigned WIDTH  = 8,
   parameter int unsigned N      = 4,
   parameter int unsigned SIGNED = 0
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [N*WIDTH-1:0]            in_data,
   input  logic [N-1:0]                  in_mask,
   input  logic                          in_valid,
   output logic                          in_ready,
   output logic [WIDTH+$clog2(N)-1:0]    out_sum,
   output logic                          out_valid,
   input  logic                          out_ready
);

   localparam int unsigned L  = $clog2(N);
   localparam int unsigned OW = WIDTH + L;

   logic [L-1:0] r_vld;
   logic         w_adv;

   // The whole pipeline moves in lockstep; it only stalls when the output is
   // occupied and the consumer is not taking it.
   assign w_adv     = !r_vld[L-1] || out_ready;
   assign in_ready  = rst_n && w_adv;
   assign out_valid = r_vld[L-1];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_vld <= '0;
      end else if (w_adv) begin
         // in_ready equals w_adv while out of reset.
         r_vld[0] <= in_valid;
         for (int j = 1; j < L; j++) begin
            r_vld[j] <= r_vld[j-1];
         end
      end
   end

   for (genvar j = 0; j < L; j++) begin : g_lvl
      localparam int unsigned Cnt = N >> (j + 1);
      localparam int unsigned Sw  = WIDTH + j + 1;

      logic [Sw-2:0] w_opnd [2*Cnt];
      logic [Sw-1:0] w_sum  [Cnt];
      logic [Sw-1:0] r_sum  [Cnt];

      if (j == 0) begin : g_src
         // Masking happens ahead of the first adder level.
         for (genvar k = 0; k < N; k++) begin : g_op
            assign w_opnd[k] = in_mask[k] ? '0 : in_data[k*WIDTH +: WIDTH];
         end
      end else begin : g_src
         for (genvar k = 0; k < 2*Cnt; k++) begin : g_op
            assign w_opnd[k] = g_lvl[j-1].r_sum[k];
         end
      end

      // One extra bit per level absorbs the carry; the extension bit is the
      // operand sign in signed mode and zero otherwise.
      for (genvar k = 0; k < Cnt; k++) begin : g_add
         assign w_sum[k] = {(SIGNED != 0) && w_opnd[2*k][Sw-2], w_opnd[2*k]}
                         + {(SIGNED != 0) && w_opnd[2*k+1][Sw-2], w_opnd[2*k+1]};
      end

      always_ff @(posedge clk) begin
         if (!rst_n) begin
            for (int k = 0; k < Cnt; k++) begin
               r_sum[k] <= '0;
            end
         end else if (w_adv) begin
            for (int k = 0; k < Cnt; k++) begin
               r_sum[k] <= w_sum[k];
            end
         end
      end
   end

   logic [OW-1:0] w_final;
   assign w_final = g_lvl[L-1].r_sum[0];
   assign out_sum = w_final;

endmodule
